// File: rtl/sevenseg_scan_driver.sv
// Purpose : multiplexed N-digit 7-segment driver with refresh timer, hex decode, per-digit dp/blank,
//           global PWM brightness, dead time between digits and tear-free double-buffered updates.
// Latency : dig/seg/frame_start are registered, 1 cycle behind the scan state they reflect.
// Backpres: none; load is always accepted, a second load before the frame boundary overwrites staging.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (synchronous release expected upstream)
//   digit_data       hex nibble per digit, digit k on bits [4k+3:4k]
//   dp, blank        per-digit decimal point (1 = lit) and blank (1 = dark)
//   brightness       global on-time level, takes effect on the next cycle
//   load             single-cycle strobe capturing digit_data/dp/blank into staging
//   update_pending   staging holds data not yet copied to the displayed buffer
//   seg              {dp,g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   dig              one-hot digit select, polarity set by DIGIT_ACTIVE_LOW
//   frame_start      one-cycle pulse coincident with the start of digit 0's slot

module sevenseg_scan_driver #(
   parameter int NUM_DIGITS       = 6,
   parameter int TICKS_PER_DIGIT  = 27000,
   parameter int BRIGHT_BITS      = 4,
   parameter int DEAD_TICKS       = 16,
   parameter int DIGIT_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW   = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [4*NUM_DIGITS-1:0]  digit_data,
   input  logic [NUM_DIGITS-1:0]    dp,
   input  logic [NUM_DIGITS-1:0]    blank,
   input  logic [BRIGHT_BITS-1:0]   brightness,
   input  logic                     load,
   output logic                     update_pending,
   output logic [7:0]               seg,
   output logic [NUM_DIGITS-1:0]    dig,
   output logic                     frame_start
);

   // Counter wide enough to hold TICKS_PER_DIGIT itself, so the window end
   // at full brightness (== TICKS_PER_DIGIT) fits without overflow.
   localparam int CW  = $clog2(TICKS_PER_DIGIT + 1);
   localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SUB = TICKS_PER_DIGIT >> BRIGHT_BITS;

   localparam logic [CW-1:0]         CNT_LAST = CW'(TICKS_PER_DIGIT - 1);
   localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0]         DEAD_END = CW'(DEAD_TICKS);
   localparam logic [7:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF  = (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                         : {NUM_DIGITS{1'b0}};

   // Scan state
   logic [CW-1:0]           r_cnt;
   logic [IW-1:0]           r_idx;

   // Staging (written by load) and active (displayed) buffers
   logic [4*NUM_DIGITS-1:0] r_stg_data;
   logic [NUM_DIGITS-1:0]   r_stg_dp;
   logic [NUM_DIGITS-1:0]   r_stg_blank;
   logic [4*NUM_DIGITS-1:0] r_act_data;
   logic [NUM_DIGITS-1:0]   r_act_dp;
   logic [NUM_DIGITS-1:0]   r_act_blank;
   logic                    r_pending;

   // Registered pin drives
   logic                    r_frame_start;
   logic [NUM_DIGITS-1:0]   r_dig;
   logic [7:0]              r_seg;

   // Combinational helpers
   logic                    w_slot_end;
   logic                    w_frame_end;
   logic [CW-1:0]           w_win_end;
   logic                    w_in_window;
   logic [3:0]              w_nib;
   logic                    w_cur_dp;
   logic                    w_cur_blank;
   logic                    w_enable;
   logic [NUM_DIGITS-1:0]   w_dig_hi;
   logic [7:0]              w_seg_hi;

   // Hex nibble to {g,f,e,d,c,b,a}, active-high
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      s = 7'h00;
      case (h)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         4'hF: s = 7'h71;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // ------------------------------------------------------------------
   // Slot timing
   // ------------------------------------------------------------------
   assign w_slot_end  = (r_cnt == CNT_LAST);
   assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else begin
         if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= w_frame_end ? '0 : r_idx + 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Double buffer: staging is copied to active only on the frame boundary,
   // so a frame is always drawn from one consistent snapshot. A load on the
   // boundary itself lands in staging after the old staging has moved out,
   // which is why it keeps pending set for another frame.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stg_data  <= '0;
         r_stg_dp    <= '0;
         r_stg_blank <= '0;
         r_act_data  <= '0;
         r_act_dp    <= '0;
         r_act_blank <= '1;
         r_pending   <= 1'b0;
      end else begin
         if (w_frame_end && r_pending) begin
            r_act_data  <= r_stg_data;
            r_act_dp    <= r_stg_dp;
            r_act_blank <= r_stg_blank;
         end
         if (load) begin
            r_stg_data  <= digit_data;
            r_stg_dp    <= dp;
            r_stg_blank <= blank;
         end
         if (load) begin
            r_pending <= 1'b1;
         end else if (w_frame_end) begin
            r_pending <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Enable window: dark for the dead time at slot start (lets the previous
   // digit's driver turn off before the next one turns on), then lit until
   // (brightness+1) sub-slots have elapsed.
   // ------------------------------------------------------------------
   always_comb begin
      w_win_end   = CW'((int'(brightness) + 1) * SUB);
      w_in_window = (r_cnt >= DEAD_END) && (r_cnt < w_win_end);
   end

   // Per-digit field selection for the digit currently being scanned
   always_comb begin
      w_nib       = 4'h0;
      w_cur_dp    = 1'b0;
      w_cur_blank = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (r_idx == IW'(k)) begin
            w_nib       = r_act_data[4*k +: 4];
            w_cur_dp    = r_act_dp[k];
            w_cur_blank = r_act_blank[k];
         end
      end
   end

   // Segments are only driven while the digit is selected, so a deselected
   // digit never sees a pattern on the shared segment lines.
   always_comb begin
      w_enable = w_in_window && !w_cur_blank;
      w_dig_hi = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         w_dig_hi[k] = w_enable && (r_idx == IW'(k));
      end
      w_seg_hi = w_enable ? {w_cur_dp, hex_to_seg(w_nib)} : 8'h00;
   end

   // ------------------------------------------------------------------
   // Output registers; polarity applied only at the final drive. Async
   // reset forces the pins inactive immediately.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dig         <= DIG_OFF;
         r_seg         <= SEG_OFF;
         r_frame_start <= 1'b0;
      end else begin
         r_dig         <= w_dig_hi ^ DIG_OFF;
         r_seg         <= w_seg_hi ^ SEG_OFF;
         r_frame_start <= w_frame_end;
      end
   end

   assign dig            = r_dig;
   assign seg            = r_seg;
   assign frame_start    = r_frame_start;
   assign update_pending = r_pending;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: 3 digits, 16 ticks per slot, 2 brightness bits, 2 dead ticks,
// active-low digits, active-high segments. A time-based model (slot/frame derived from cycles since
// reset release) is compared every cycle, plus hand-computed per-frame tables.

module tb_sevenseg_scan_driver;

   localparam int ND   = 3;
   localparam int T    = 16;
   localparam int BB   = 2;
   localparam int DT   = 2;
   localparam int SUBV = T >> BB;
   localparam int FR   = ND * T;

   localparam logic [6:0] SEGT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic        clk;
   logic        rst_n;
   logic [11:0] digit_data;
   logic [2:0]  dp;
   logic [2:0]  blank;
   logic [1:0]  brightness;
   logic        load;
   logic        update_pending;
   logic [7:0]  seg;
   logic [2:0]  dig;
   logic        frame_start;

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;

   sevenseg_scan_driver #(
      .NUM_DIGITS(ND), .TICKS_PER_DIGIT(T), .BRIGHT_BITS(BB), .DEAD_TICKS(DT),
      .DIGIT_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .digit_data(digit_data), .dp(dp), .blank(blank),
      .brightness(brightness), .load(load), .update_pending(update_pending),
      .seg(seg), .dig(dig), .frame_start(frame_start)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Model: position in the scan is purely a function of the number of
   // clock edges since reset release.
   // ------------------------------------------------------------------
   int          m_t;
   int          mc;
   int          mi;
   logic        men;
   logic [11:0] msh;
   logic [11:0] s_data, a_data;
   logic [2:0]  s_dp, a_dp, s_bl, a_bl;
   logic        m_pend, m_fs;
   logic [2:0]  m_dig;
   logic [7:0]  m_seg;

   initial begin
      m_t = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_t = 0;
            s_data = '0; s_dp = '0; s_bl = '0;
            a_data = '0; a_dp = '0; a_bl = 3'b111;
            m_pend = 1'b0; m_fs = 1'b0;
            m_dig = 3'b111; m_seg = 8'h00;
         end else begin
            mc  = m_t % T;
            mi  = (m_t / T) % ND;
            men = (mc >= DT) && (mc < (int'(brightness) + 1) * SUBV) && !a_bl[mi];
            msh = a_data >> (4 * mi);
            m_dig = men ? ~(3'b001 << mi) : 3'b111;
            m_seg = men ? {a_dp[mi], SEGT[msh[3:0]]} : 8'h00;
            m_fs  = ((m_t % FR) == FR - 1);
            if (m_fs && m_pend) begin
               a_data = s_data; a_dp = s_dp; a_bl = s_bl;
            end
            if (m_fs) m_pend = 1'b0;
            if (load) begin
               s_data = digit_data; s_dp = dp; s_bl = blank; m_pend = 1'b1;
            end
            m_t++;
         end
      end
   end

   // Every-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("mon_dig",  32'(dig),            32'(m_dig));
            chk("mon_seg",  32'(seg),            32'(m_seg));
            chk("mon_fs",   32'(frame_start),    32'(m_fs));
            chk("mon_pend", 32'(update_pending), 32'(m_pend));
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (always called at a falling edge)
   // ------------------------------------------------------------------
   task automatic wait_phase(input int ph);
      int n;
      n = 0;
      while ((m_t % FR) != ph && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         checks++;
         errors++;
         $display("FAIL wait_phase_timeout phase=%0d waited=%0d limit=500", ph, n);
      end
   endtask

   task automatic pulse_load();
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Check one full frame against hand-written tables: digit k lit for
   // cnt 2..hi unless blanked, outputs lagging the scan by one cycle.
   task automatic check_frame(input string nm, input int hi, input logic [2:0] bl,
                              input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
      logic [2:0] dl [3];
      logic [7:0] sl [3];
      dl[0] = 3'b110; dl[1] = 3'b101; dl[2] = 3'b011;
      sl[0] = s0;     sl[1] = s1;     sl[2] = s2;
      wait_phase(0);
      for (int k = 0; k < FR; k++) begin
         int   di;
         int   c;
         logic on;
         di = k / T;
         c  = k % T;
         on = !bl[di] && (c >= 2) && (c <= hi);
         @(negedge clk);
         chk({nm, "_dig"}, 32'(dig), 32'(on ? dl[di] : 3'b111));
         chk({nm, "_seg"}, 32'(seg), 32'(on ? sl[di] : 8'h00));
      end
   endtask

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      int first;
      rst_n = 1'b0; load = 1'b0; digit_data = '0; dp = '0; blank = '0; brightness = '0;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;

      // 1: reset held while inputs toggle
      for (int k = 0; k < 6; k++) begin
         load       = k[0];
         digit_data = 12'($urandom);
         dp         = 3'($urandom);
         blank      = 3'($urandom);
         brightness = 2'(k);
         @(negedge clk);
         chk("rst_dig",  32'(dig),            32'h7);
         chk("rst_seg",  32'(seg),            32'h00);
         chk("rst_pend", 32'(update_pending), 32'h0);
         chk("rst_fs",   32'(frame_start),    32'h0);
      end
      load = 1'b0; brightness = 2'd3; blank = '0;
      rst_n = 1'b1;
      first = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (frame_start === 1'b1 && first < 0) first = k;
      end
      chk("first_frame_start_cycle", 32'(first), 32'd48);

      // 2: load and display at full brightness
      digit_data = 12'h3A5; dp = 3'b010; blank = 3'b000;
      pulse_load();
      chk("t2_pend_set", 32'(update_pending), 32'h1);
      wait_phase(0);
      chk("t2_pend_clear", 32'(update_pending), 32'h0);
      check_frame("t2", 15, 3'b000, 8'h6D, 8'hF7, 8'h4F);

      // 3: brightness levels and a mid-slot change
      brightness = 2'd0;
      check_frame("t3_b0", 3, 3'b000, 8'h6D, 8'hF7, 8'h4F);
      brightness = 2'd2;
      check_frame("t3_b2", 11, 3'b000, 8'h6D, 8'hF7, 8'h4F);
      brightness = 2'd3;
      wait_phase(6);
      chk("t3_on_before", 32'(dig), 32'h6);
      chk("t3_seg_before", 32'(seg), 32'h6D);
      brightness = 2'd0;
      @(negedge clk);
      chk("t3_off_next_cycle", 32'(dig), 32'h7);
      brightness = 2'd3;
      @(negedge clk);
      chk("t3_on_again", 32'(dig), 32'h6);

      // 4: blank digit 1
      blank = 3'b010;
      pulse_load();
      check_frame("t4", 15, 3'b010, 8'h6D, 8'hF7, 8'h4F);

      // 5: load A mid-frame, load B on the boundary cycle
      blank = 3'b000;
      wait_phase(20);
      digit_data = 12'h0F8; dp = 3'b100;
      pulse_load();
      wait_phase(47);
      digit_data = 12'hCE1; dp = 3'b001;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("t5_pend_during_A", 32'(update_pending), 32'h1);
      check_frame("t5_A", 15, 3'b000, 8'h7F, 8'h71, 8'hBF);
      chk("t5_pend_during_B", 32'(update_pending), 32'h0);
      check_frame("t5_B", 15, 3'b000, 8'h86, 8'h79, 8'h39);

      // 6: asynchronous reset mid-slot (idx 1, cnt 7) with a load pending
      wait_phase(20);
      digit_data = 12'h742; dp = 3'b000;
      pulse_load();
      wait_phase(23);
      chk("t6_lit_before", 32'(dig), 32'h5);
      chk("t6_pend_before", 32'(update_pending), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_dig",  32'(dig),            32'h7);
      chk("t6_async_seg",  32'(seg),            32'h00);
      chk("t6_async_pend", 32'(update_pending), 32'h0);
      chk("t6_async_fs",   32'(frame_start),    32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check_frame("t6_dark", 15, 3'b111, 8'h00, 8'h00, 8'h00);
      pulse_load();
      check_frame("t6_C", 15, 3'b000, 8'h5B, 8'h66, 8'h07);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog elapsed=%0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
